// File: rtl/loop_gear_pkg.sv
// Shared state encoding and widths for the loop gear-shift controller.
package loop_gear_pkg;
  localparam int ERR_W       = 12;
  localparam int MAG_W       = 11;
  localparam int MIN_WIN_EXP = 4;

  localparam logic [1:0] GEAR_ACQ  = 2'd0;
  localparam logic [1:0] GEAR_TRK1 = 2'd1;
  localparam logic [1:0] GEAR_TRK2 = 2'd2;
  localparam logic [1:0] GEAR_TRK3 = 2'd3;

  // State values equal the bandwidth divisor exponent they drive.
  typedef enum logic [1:0] {
    ACQ  = GEAR_ACQ,
    TRK1 = GEAR_TRK1,
    TRK2 = GEAR_TRK2,
    TRK3 = GEAR_TRK3
  } gear_state_t;
endpackage

// File: rtl/error_mag_avg.sv
// Windowed average of |error|: saturating magnitude, accumulator, sample
// counter and a per-window latch of the window length exponent.
module error_mag_avg
  import loop_gear_pkg::*;
#(
  parameter int MAX_WIN_EXP = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [ERR_W-1:0] error,
  input  logic [3:0]       win_exp,
  input  logic             force_acq,
  output logic [MAG_W-1:0] avg_mag,
  output logic             win_done
);
  localparam int ACC_W = MAG_W + MAX_WIN_EXP;
  localparam logic [3:0] MIN_EXP4 = 4'(MIN_WIN_EXP);
  localparam logic [3:0] MAX_EXP4 = 4'(MAX_WIN_EXP);

  // -2048 has no positive twin in 12 bits, so it folds onto 2047.
  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [ERR_W-1:0] e);
    logic signed [ERR_W-1:0] neg;
    if (e == {1'b1, {(ERR_W-1){1'b0}}}) return '1;
    if (e[ERR_W-1]) begin
      neg = -e;
      return neg[MAG_W-1:0];
    end
    return e[MAG_W-1:0];
  endfunction

  function automatic logic [3:0] clamp_exp(input logic [3:0] w);
    if (w < MIN_EXP4) return MIN_EXP4;
    if (w > MAX_EXP4) return MAX_EXP4;
    return w;
  endfunction

  logic signed [ERR_W-1:0]   err_s;
  logic [MAG_W-1:0]          mag;
  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          sum;
  logic [MAX_WIN_EXP-1:0]    samp_cnt;
  logic [MAX_WIN_EXP-1:0]    last_cnt;
  logic [3:0]                win_exp_q;
  logic                      last;

  assign err_s = error;
  assign mag   = sat_mag(err_s);
  assign sum   = acc + ACC_W'(mag);

  always_comb begin
    last_cnt = '0;
    for (int i = 0; i < MAX_WIN_EXP; i++) last_cnt[i] = (i < int'(win_exp_q));
  end

  assign last = clk_en && (samp_cnt == last_cnt);

  // Window length is re-latched only when a new window begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      samp_cnt  <= '0;
      avg_mag   <= '0;
      win_done  <= 1'b0;
      win_exp_q <= clamp_exp(win_exp);
    end else if (force_acq) begin
      acc       <= '0;
      samp_cnt  <= '0;
      win_done  <= 1'b0;
      win_exp_q <= clamp_exp(win_exp);
    end else begin
      win_done <= 1'b0;
      if (last) begin
        avg_mag   <= MAG_W'(sum >> win_exp_q);
        acc       <= '0;
        samp_cnt  <= '0;
        win_done  <= 1'b1;
        win_exp_q <= clamp_exp(win_exp);
      end else if (clk_en) begin
        acc      <= sum;
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/loop_gear_shift.sv
// Acquisition/track gear-shift controller for the loop filters.
// Define GEAR_STEPDOWN_EN to drop one gear per loss event instead of straight to ACQ.
module loop_gear_shift
  import loop_gear_pkg::*;
#(
  parameter int MAX_WIN_EXP = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic [11:0] error,
  input  logic [3:0]  winExp,
  input  logic [10:0] lockThresh,
  input  logic [3:0]  lockWins,
  input  logic [3:0]  lossWins,
  input  logic        forceAcq,
  output logic        track,
  output logic [1:0]  acqTrackControl,
  output logic        lockDetect,
  output logic [10:0] avgMag,
  output logic        winDone
);
  gear_state_t state, state_nxt;
  logic [3:0]  good_cnt, good_nxt;
  logic [3:0]  bad_cnt, bad_nxt;
  logic [3:0]  lock_n, loss_n;
  logic        good_win;

  error_mag_avg #(.MAX_WIN_EXP(MAX_WIN_EXP)) u_avg (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clkEn),
    .error    (error),
    .win_exp  (winExp),
    .force_acq(forceAcq),
    .avg_mag  (avgMag),
    .win_done (winDone)
  );

  assign lock_n   = (lockWins == 4'd0) ? 4'd1 : lockWins;
  assign loss_n   = (lossWins == 4'd0) ? 4'd1 : lossWins;
  assign good_win = avgMag < lockThresh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACQ;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  // Evaluation runs the cycle after winDone; forceAcq takes priority.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    if (forceAcq) begin
      state_nxt = ACQ;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (winDone) begin
      if (good_win) begin
        bad_nxt = '0;
        if (state == TRK3) begin
          good_nxt = (good_cnt >= lock_n) ? lock_n : good_cnt + 4'd1;
        end else if ({1'b0, good_cnt} + 5'd1 >= {1'b0, lock_n}) begin
          good_nxt = '0;
          case (state)
            ACQ:     state_nxt = TRK1;
            TRK1:    state_nxt = TRK2;
            default: state_nxt = TRK3;
          endcase
        end else begin
          good_nxt = good_cnt + 4'd1;
        end
      end else begin
        good_nxt = '0;
        if (state == ACQ) begin
          bad_nxt = '0;
        end else if ({1'b0, bad_cnt} + 5'd1 >= {1'b0, loss_n}) begin
          bad_nxt = '0;
`ifdef GEAR_STEPDOWN_EN
          case (state)
            TRK3:    state_nxt = TRK2;
            TRK2:    state_nxt = TRK1;
            default: state_nxt = ACQ;
          endcase
`else
          state_nxt = ACQ;
`endif
        end else begin
          bad_nxt = bad_cnt + 4'd1;
        end
      end
    end
  end

  assign acqTrackControl = state;
  assign track           = (state != ACQ);
  assign lockDetect      = (state != ACQ);
endmodule

// File: doc/loop_gear_shift.md
# loop_gear_shift

Acquisition/track gear-shift controller for the carrier and bit-sync loop filters. It measures the average magnitude of the same 12-bit loop error that feeds the lead-gain shifter. From that measurement it produces the `track` and `acqTrackControl` inputs the shifter consumes, so the shifter narrows loop bandwidth in steps of 1/2, 1/4 and 1/8 as lock quality is demonstrated. It sits beside the loop filter, driven by the same error stream and clock enable.

## Interface
Parameters:
- `MAX_WIN_EXP`, default 15: largest supported `winExp`; sets the accumulator width to 11+`MAX_WIN_EXP` bits.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `clkEn`, input, 1: sample enable. Error is valid only when this is high.
- `error`, input, 12: signed loop error, two's complement.
- `winExp`, input, 4: window length is 2^winExp samples. Legal range is 4..MAX_WIN_EXP; values below 4 are treated as 4.
- `lockThresh`, input, 11: average-magnitude threshold. A window is "good" when `avgMag` < `lockThresh`.
- `lockWins`, input, 4: consecutive good windows required to shift up one gear. 0 is treated as 1.
- `lossWins`, input, 4: consecutive bad windows that declare loss of lock. 0 is treated as 1.
- `forceAcq`, input, 1: synchronous. Returns the controller to ACQ and clears the counters.
- `track`, output, 1: to the lead/lag gain blocks.
- `acqTrackControl`, output, 2: bandwidth divisor exponent for the gain blocks.
- `lockDetect`, output, 1: high in any TRACK state.
- `avgMag`, output, 11: the last completed window's average |error|.
- `winDone`, output, 1: one-clk pulse when `avgMag` updates.

## Operation
- Magnitude: mag = |error|. The value -2048 saturates to 2047, so mag is 11 bits unsigned.
- Accumulation:
  - On each clkEn, acc += mag and sampCnt increments.
  - `winExp` is sampled into `winExpQ` when a window starts, i.e. at reset, at forceAcq, and at each window close. Changes mid-window are ignored until the next window.
- Window close: on the clkEn where sampCnt == 2^winExpQ−1:
  - avgMag <= (acc+mag) >> winExpQ, truncated.
  - acc and sampCnt clear, and winDone pulses.
- States (one-hot or encoded; outputs are registered):
  - ACQ: track=0, ctrl=0.
  - TRK1: track=1, ctrl=1.
  - TRK2: track=1, ctrl=2.
  - TRK3: track=1, ctrl=3.
- Per window evaluation:
  - Good window: goodCnt increments and badCnt clears. If goodCnt reaches lockWins, the FSM moves up one state and goodCnt clears. In TRK3 goodCnt saturates and the state holds.
  - Bad window: badCnt increments and goodCnt clears. If badCnt reaches lossWins, the FSM drops (see Configuration) and badCnt clears. In ACQ, bad windows only clear goodCnt; badCnt stays 0.
- A threshold of 0 means no window is ever good, so the FSM stays in ACQ.
- forceAcq overrides evaluation in the same cycle, including when it coincides with a window close: the state goes to ACQ, acc/sampCnt/goodCnt/badCnt clear, and that window's avgMag is discarded (avgMag holds).

## Timing
- Reset values: track=0, acqTrackControl=0, lockDetect=0, avgMag=0, winDone=0; all counters and the accumulator are 0; state=ACQ.
- Final window sample accepted at edge E: avgMag and winDone are valid after E.
- The state and outputs update at edge E+1. This gives 2 clk from the last sample to the new `track`/`acqTrackControl`, which the gain block then registers one more cycle.
- Evaluation occurs at edge E+1 regardless of clkEn at that edge.
- clkEn low: the accumulator and counters hold. Evaluation still completes if it is pending.
- Windows are back-to-back, with no dead samples between them.
- Reset mid-window or mid-evaluation: everything returns to reset values at the next edge, and the pending evaluation is dropped.

## Configuration
- `GEAR_STEPDOWN_EN` defined: a loss event drops one gear (TRK3→TRK2→TRK1→ACQ).
- Not defined: a loss event from any TRK state goes directly to ACQ.
- Good-window behaviour is identical in both builds.

## Structure
- Package `loop_gear_pkg` holds:
  - the state enum (ACQ, TRK1, TRK2, TRK3);
  - the 2-bit gear encodings, equal to acqTrackControl;
  - constants ERR_W=12, MAG_W=11, MIN_WIN_EXP=4.
- Sub-module `error_mag_avg`: saturating magnitude, accumulator, sample counter, winExp latch. It outputs avgMag and winDone.
- The top level holds the gear FSM and the good/bad counters.

## Test plan
Common setup unless stated: winExp=4 (16 samples), clkEn always high.

- Reset behaviour: error=16, lockThresh=32, lockWins=2. Expect:
  - after reset, outputs are 0;
  - winDone every 16 clkEn, avgMag=16;
  - TRK1 2 clk after sample 32, TRK2 after sample 64, TRK3 after sample 96, then holds.
- Saturation: error=−2048 constant gives avgMag=2047. error alternating +100/−100 gives avgMag=100.
- Loss of lock: in TRK3 with lossWins=3, switch to error=500.
  - Without the macro: ACQ 2 clk after the third bad window.
  - With `GEAR_STEPDOWN_EN`: TRK2, then TRK1 and ACQ after each further 3 bad windows.
- Interrupted streaks: alternate good and bad windows with lockWins=2 and lossWins=2. Expect no state change ever.
- winExp change: set winExp=6 at sample 5 of a window. Expect the current window to close at 16 samples and the next at 64. Also, clkEn at 1/4 duty stretches windows ×4 in clk but not in samples.
- forceAcq in TRK2 on a window-closing sample: next state is ACQ, avgMag unchanged, winDone not pulsed, and the next window counts from sample 0.
